// File: rtl/mem_transfer_ctrl.sv
// rtl/mem_transfer_ctrl.sv - pairwise A-to-B transfer sequencer: reads word pairs from A, writes their sums to B
module mem_transfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int A_AW   = 3,
  parameter int B_AW   = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [DATA_W-1:0] DataA,
  output logic [A_AW-1:0]   AddrA,
  output logic [B_AW-1:0]   AddrB,
  output logic [DATA_W:0]   DataB,
  output logic              WEB,
  output logic              IncA,
  output logic              IncB,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {IDLE, READ0, READ1, WRITE, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] reg_x;
  logic [DATA_W-1:0] reg_y;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      AddrA <= '0;
      AddrB <= '0;
      reg_x <= '0;
      reg_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            AddrA <= '0;
            AddrB <= '0;
            state <= READ0;
          end
        end
        READ0: begin
          if (Abort) begin
            state <= IDLE;
          end else begin
            reg_x <= DataA;
            AddrA <= AddrA + A_AW'(1);
            state <= READ1;
          end
        end
        READ1: begin
          if (Abort) begin
            state <= IDLE;
          end else begin
            reg_y <= DataA;
            AddrA <= AddrA + A_AW'(1);
            state <= WRITE;
          end
        end
        WRITE: begin
          if (Abort) begin
            state <= IDLE;
          end else begin
            // AddrB wraps to 0 on the final write, leaving it ready for the next run
            AddrB <= AddrB + B_AW'(1);
            state <= (AddrB == {B_AW{1'b1}}) ? DONE : READ0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign DataB = {1'b0, reg_x} + {1'b0, reg_y};
  assign Busy  = (state == READ0) || (state == READ1) || (state == WRITE);
  assign Done  = (state == DONE);
  // An aborted cycle neither writes nor advances a counter
  assign WEB   = (state == WRITE) && !Abort;
  assign IncA  = ((state == READ0) || (state == READ1)) && !Abort;
  assign IncB  = (state == WRITE) && !Abort;

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// tb/tb_mem_transfer_ctrl.sv - directed self-checking bench for mem_transfer_ctrl
module tb_mem_transfer_ctrl;

  logic       clk;
  logic       Reset;
  logic       Start;
  logic       Abort;
  logic [7:0] DataA;
  logic [2:0] AddrA;
  logic [1:0] AddrB;
  logic [8:0] DataB;
  logic       WEB;
  logic       IncA;
  logic       IncB;
  logic       Busy;
  logic       Done;

  logic [7:0] mem_a [8];
  logic [8:0] exp_b [4];
  int checks;
  int errors;

  mem_transfer_ctrl #(.DATA_W(8), .A_AW(3), .B_AW(2)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Abort(Abort), .DataA(DataA),
    .AddrA(AddrA), .AddrB(AddrB), .DataB(DataB), .WEB(WEB),
    .IncA(IncA), .IncB(IncB), .Busy(Busy), .Done(Done)
  );

  assign DataA = mem_a[AddrA];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_a(input logic [63:0] words);
    for (int i = 0; i < 8; i++) mem_a[i] = words[63-8*i -: 8];
  endtask

  // Drives a Start in cycle 0 and checks the whole 14-cycle transfer against exp_b
  task automatic run_full(input string name, input logic abort_with_start);
    logic exp_web, exp_done, exp_busy;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      Start = (c == 0);
      Abort = (c == 0) && abort_with_start;
      #1;
      if (c >= 1) begin
        exp_web  = (c == 3) || (c == 6) || (c == 9) || (c == 12);
        exp_done = (c == 13);
        exp_busy = (c >= 1) && (c <= 12);
        checks++;
        if (WEB !== exp_web) begin
          errors++; $display("FAIL %s web c%0d got %b want %b", name, c, WEB, exp_web);
        end
        checks++;
        if (Done !== exp_done) begin
          errors++; $display("FAIL %s done c%0d got %b want %b", name, c, Done, exp_done);
        end
        checks++;
        if (Busy !== exp_busy) begin
          errors++; $display("FAIL %s busy c%0d got %b want %b", name, c, Busy, exp_busy);
        end
        if (exp_web) begin
          checks++;
          if (AddrB !== 2'(c/3 - 1)) begin
            errors++; $display("FAIL %s addrb c%0d got %0d want %0d", name, c, AddrB, c/3 - 1);
          end
          checks++;
          if (DataB !== exp_b[c/3 - 1]) begin
            errors++; $display("FAIL %s datab c%0d got %0d want %0d", name, c, DataB, exp_b[c/3 - 1]);
          end
        end
      end
      if (c == 1 || c == 14) begin
        checks++;
        if (AddrA !== 3'd0) begin
          errors++; $display("FAIL %s addra c%0d got %0d want 0", name, c, AddrA);
        end
      end
      if (c == 14) begin
        checks++;
        if (AddrB !== 2'd0) begin
          errors++; $display("FAIL %s addrb_end got %0d want 0", name, AddrB);
        end
      end
    end
    Abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({AddrA, AddrB, DataB, WEB, IncA, IncB, Busy, Done} !== 19'd0) begin
      errors++;
      $display("FAIL reset outputs got a%0d b%0d d%0d w%b ia%b ib%b bs%b dn%b want all 0",
               AddrA, AddrB, DataB, WEB, IncA, IncB, Busy, Done);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    load_a({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    exp_b[0] = 9'd3; exp_b[1] = 9'd7; exp_b[2] = 9'd11; exp_b[3] = 9'd15;
    run_full("basic", 1'b0);
  endtask

  task automatic test_overflow();
    load_a({8'd255, 8'd255, 8'd128, 8'd128, 8'd0, 8'd0, 8'd1, 8'd254});
    exp_b[0] = 9'd510; exp_b[1] = 9'd256; exp_b[2] = 9'd0; exp_b[3] = 9'd255;
    run_full("overflow", 1'b0);
  endtask

  task automatic test_start_held();
    logic exp_web, exp_done;
    load_a({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      Start = (c < 20);
      #1;
      if (c >= 1) begin
        exp_web  = (c == 3) || (c == 6) || (c == 9) || (c == 12) ||
                   (c == 17) || (c == 20) || (c == 23) || (c == 26);
        exp_done = (c == 13) || (c == 27);
        checks++;
        if (WEB !== exp_web) begin
          errors++; $display("FAIL held web c%0d got %b want %b", c, WEB, exp_web);
        end
        checks++;
        if (Done !== exp_done) begin
          errors++; $display("FAIL held done c%0d got %b want %b", c, Done, exp_done);
        end
      end
      if (c == 17) begin
        checks++;
        if (AddrB !== 2'd0 || DataB !== 9'd3) begin
          errors++; $display("FAIL held second_write got b%0d d%0d want b0 d3", AddrB, DataB);
        end
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_abort();
    load_a({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      Start = (c == 0);
      Abort = (c == 6);
      #1;
      if (c == 6) begin
        checks++;
        if (WEB !== 1'b0) begin
          errors++; $display("FAIL abort web got %b want 0", WEB);
        end
      end
      if (c >= 7) begin
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
          errors++; $display("FAIL abort idle c%0d got busy %b done %b want 0 0", c, Busy, Done);
        end
      end
      if (c == 7) begin
        checks++;
        if (AddrB !== 2'd1) begin
          errors++; $display("FAIL abort addrb got %0d want 1", AddrB);
        end
      end
    end
    Abort = 1'b0;
    exp_b[0] = 9'd3; exp_b[1] = 9'd7; exp_b[2] = 9'd11; exp_b[3] = 9'd15;
    run_full("abort_restart", 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      Start = (c == 0) || (c == 6);
      Reset = (c == 5) || (c == 6);
      #1;
      if (c == 6) begin
        checks++;
        if ({AddrA, AddrB, DataB, WEB, IncA, IncB, Busy, Done} !== 19'd0) begin
          errors++;
          $display("FAIL reset_mid outputs got a%0d b%0d d%0d w%b ia%b ib%b bs%b dn%b want all 0",
                   AddrA, AddrB, DataB, WEB, IncA, IncB, Busy, Done);
        end
      end
      if (c >= 7) begin
        checks++;
        if (Busy !== 1'b0) begin
          errors++; $display("FAIL reset_start busy c%0d got %b want 0", c, Busy);
        end
      end
    end
    Start = 1'b0; Reset = 1'b0;
  endtask

  task automatic test_start_abort();
    load_a({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
    exp_b[0] = 9'd3; exp_b[1] = 9'd7; exp_b[2] = 9'd11; exp_b[3] = 9'd15;
    run_full("start_abort", 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'd0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_held();
    test_abort();
    test_reset_mid();
    test_start_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
